rr_fifo_arbiter: RTL
====================

Name: rr_fifo_arbiter

Overview:
- Round-robin scheduler that drains NUM_REQ per-master APB slave FIFOs into a single downstream transaction port of the interconnect.
- Each cycle it picks one non-empty FIFO, pops one entry (address, write data, write flag) and registers it.
- It presents the entry downstream with a valid/ready handshake, then rotates priority to the next requester.

Parameters:
NUM_REQ, 4, number of requesting FIFOs (2..8)
AW, 32, address width
DW, 32, write-data width
IDW, $clog2(NUM_REQ), width of the source-ID field

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
req_empty_i  input  NUM_REQ  per-FIFO empty flag; bit i=1 means FIFO i holds nothing
req_write_i  input  NUM_REQ  per-FIFO write/read type of its head entry
req_addr_i  input  NUM_REQ*AW  per-FIFO head address; slice i = [i*AW +: AW]; valid combinationally while pop_o[i]=1
req_wdata_i  input  NUM_REQ*DW  per-FIFO head write data; same slicing and validity as req_addr_i
pop_o  output  NUM_REQ  one-hot pop strobe, at most one bit high, one cycle per entry
m_valid_o  output  1  downstream transaction valid
m_ready_i  input  1  downstream accept
m_write_o  output  1  1 = write, 0 = read
m_addr_o  output  AW  transaction address
m_wdata_o  output  DW  transaction write data; 0 for reads
m_src_o  output  IDW  index of the FIFO the entry came from
grant_o  output  NUM_REQ  one-hot copy of the current owner while m_valid_o=1, else 0

Behaviour:
- Reset is asynchronous and active-high. While reset=1:
  - pop_o=0, m_valid_o=0, m_write_o=0, m_addr_o=0, m_wdata_o=0, m_src_o=0, grant_o=0.
  - last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
  - State=IDLE.
- FSM has two states, IDLE and SEND.
- Arbitration function: scan indices last_grant+1, last_grant+2, ... modulo NUM_REQ. The winner is the first index with req_empty_i=0. There is no winner if all FIFOs are empty.
- IDLE:
  - If a winner w exists: pop_o[w]=1 combinationally this cycle.
  - On the clock edge: register m_addr_o=req_addr_i[w], m_write_o=req_write_i[w], m_wdata_o=(req_write_i[w] ? req_wdata_i[w] : 0), m_src_o=w, last_grant=w. Go to SEND.
  - Otherwise stay in IDLE with pop_o=0.
- SEND:
  - m_valid_o=1 and grant_o[m_src_o]=1.
  - All m_* outputs stay stable until the handshake (m_valid_o && m_ready_i).
  - pop_o=0 while m_ready_i=0.
- SEND with handshake:
  - Arbitrate in the same cycle, using the just-updated last_grant=m_src_o.
  - If a winner exists: pop it, load the new entry and stay in SEND. This gives back-to-back transfers at 1 per cycle.
  - Otherwise go to IDLE; m_valid_o=0 on the next cycle.
- Latency: first non-empty flag seen in IDLE to m_valid_o=1 is 1 cycle. Sustained throughput is 1 transaction per cycle when m_ready_i=1.
- Fairness:
  - A requester that stays non-empty is served within NUM_REQ grants.
  - The just-served requester has lowest priority, even if it is the only non-empty one; it is then re-granted immediately.
- Empty FIFOs are skipped with no idle cycle. Wrap from NUM_REQ-1 to 0 is seamless.
- The block never pops a FIFO whose req_empty_i=1.
- req_empty_i changing while in SEND without a handshake has no effect.
- Reset mid-SEND: the held entry is discarded (already popped, not replayed). m_valid_o drops asynchronously and priority returns to requester 0.
- m_ready_i is ignored when m_valid_o=0.

Test Plan:
1. Only FIFO 2 non-empty with 1 entry (write, addr 0x1000_0010, wdata 0xDEAD_BEEF), m_ready_i=1 -> pop_o=4'b0100 for one cycle; next cycle m_valid_o=1, m_addr_o=0x1000_0010, m_wdata_o=0xDEAD_BEEF, m_src_o=2, grant_o=4'b0100; the following cycle m_valid_o=0.
2. All four FIFOs hold 3 entries each, m_ready_i=1 -> m_src_o sequence 0,1,2,3,0,1,2,3,0,1,2,3 on consecutive cycles; exactly 12 pops; then IDLE.
3. FIFOs 1 and 3 non-empty, FIFOs 0 and 2 empty -> grant order 1,3,1,3; pop_o[0] and pop_o[2] never asserted.
4. Backpressure: m_ready_i=0 for 5 cycles with entry from FIFO 0 (read, addr 0x20) -> m_* outputs unchanged, m_wdata_o=0, pop_o=0 for all 5 cycles; one cycle after m_ready_i rises, FIFO 1 is granted.
5. Single FIFO 0 with 4 entries -> granted on 4 consecutive cycles, entries in FIFO order.
6. Reset asserted mid-SEND (m_src_o=2) -> m_valid_o and grant_o go to 0 without a clock edge; after release with all FIFOs non-empty, FIFO 0 is granted first.

Source files
------------

// File: rtl/rr_fifo_arbiter.sv
// rr_fifo_arbiter
//   Round-robin scheduler that drains NUM_REQ per-master FIFOs into one
//   downstream valid/ready transaction port. In each cycle where the output
//   register is free or being accepted, one non-empty FIFO is popped. Its head
//   entry is registered and then presented downstream. Priority rotates so that
//   the requester served last has the lowest priority.
//
// Ports
//   clk, reset    rising-edge clock, asynchronous active-high reset
//   req_empty_i   per-FIFO empty flag (1 = nothing to pop)
//   req_write_i   per-FIFO head entry type (1 = write)
//   req_addr_i    per-FIFO head address, slice i = [i*AW +: AW]
//   req_wdata_i   per-FIFO head write data, slice i = [i*DW +: DW]
//   pop_o         one-hot pop strobe, combinational
//   m_valid_o     downstream transaction valid
//   m_ready_i     downstream accept
//   m_write_o     1 = write, 0 = read
//   m_addr_o      transaction address
//   m_wdata_o     transaction write data, 0 for reads
//   m_src_o       index of the source FIFO
//   grant_o       one-hot owner while m_valid_o=1, else 0
module rr_fifo_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_empty_i,
   input  logic [NUM_REQ-1:0]    req_write_i,
   input  logic [NUM_REQ*AW-1:0] req_addr_i,
   input  logic [NUM_REQ*DW-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]    pop_o,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic                  m_write_o,
   output logic [AW-1:0]         m_addr_o,
   output logic [DW-1:0]         m_wdata_o,
   output logic [IDW-1:0]        m_src_o,
   output logic [NUM_REQ-1:0]    grant_o
);

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t         state;
   logic [IDW-1:0] last_grant;
   logic           found;
   logic [IDW-1:0] win;
   logic [IDW-1:0] cand;
   logic           may_pop;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Scan starts one past the last grant, so the requester just served is
   // visited last and is only re-granted when nobody else is waiting.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = IDW'((32'(last_grant) + k) % NUM_REQ);
         if (!found && !req_empty_i[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // The output register can take a new entry when empty (IDLE) or when it
   // is handing its current entry off in this cycle.
   always_comb begin
      may_pop = !reset && found && ((state == IDLE) || m_ready_i);
      pop_o   = '0;
      if (may_pop) begin
         pop_o[win] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= IDW'(NUM_REQ - 1);
         m_valid_o  <= 1'b0;
         m_write_o  <= 1'b0;
         m_addr_o   <= '0;
         m_wdata_o  <= '0;
         m_src_o    <= '0;
         grant_o    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  state      <= SEND;
                  last_grant <= win;
                  m_valid_o  <= 1'b1;
                  m_write_o  <= req_write_i[win];
                  m_addr_o   <= req_addr_i[win*AW +: AW];
                  m_wdata_o  <= req_write_i[win] ? req_wdata_i[win*DW +: DW] : '0;
                  m_src_o    <= win;
                  grant_o    <= onehot(win);
               end
            end
            SEND: begin
               if (m_ready_i) begin
                  if (found) begin
                     last_grant <= win;
                     m_write_o  <= req_write_i[win];
                     m_addr_o   <= req_addr_i[win*AW +: AW];
                     m_wdata_o  <= req_write_i[win] ? req_wdata_i[win*DW +: DW] : '0;
                     m_src_o    <= win;
                     grant_o    <= onehot(win);
                  end else begin
                     state     <= IDLE;
                     m_valid_o <= 1'b0;
                     grant_o   <= '0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
